// File: rtl/alu_pkg.sv
// Shared opcode, flag-index, compare-bit and FSM state definitions for alu_pipe.
// The MUL state is present only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_OR   = 4'd2;
  localparam logic [3:0] OPC_AND  = 4'd3;
  localparam logic [3:0] OPC_XOR  = 4'd4;
  localparam logic [3:0] OPC_NOT  = 4'd5;
  localparam logic [3:0] OPC_MUL  = 4'd6;
  localparam logic [3:0] OPC_LOAD = 4'd8;
  localparam logic [3:0] OPC_CMP  = 4'd9;
  localparam logic [3:0] OPC_SHL  = 4'd10;
  localparam logic [3:0] OPC_SHR  = 4'd11;
  localparam logic [3:0] OPC_JMPA = 4'd12;
  localparam logic [3:0] OPC_JMPR = 4'd13;

  // Reserved codes are listed so every 4-bit pattern is a legal enum value.
  typedef enum logic [3:0] {
    OP_ADD   = OPC_ADD,
    OP_SUB   = OPC_SUB,
    OP_OR    = OPC_OR,
    OP_AND   = OPC_AND,
    OP_XOR   = OPC_XOR,
    OP_NOT   = OPC_NOT,
    OP_MUL   = OPC_MUL,
    OP_RSV7  = 4'd7,
    OP_LOAD  = OPC_LOAD,
    OP_CMP   = OPC_CMP,
    OP_SHL   = OPC_SHL,
    OP_SHR   = OPC_SHR,
    OP_JMPA  = OPC_JMPA,
    OP_JMPR  = OPC_JMPR,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  localparam int CMP_EQ = 0;
  localparam int CMP_AZ = 1;
  localparam int CMP_BZ = 2;
  localparam int CMP_GT = 3;
  localparam int CMP_LT = 4;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MUL  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, with sign handling.
// Magnitudes are multiplied; the 2*DATA_W product is negated when operand signs differ.
module alu_mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  done_o,
  output logic                  signed_o,
  output logic [2*DATA_W-1:0]   prod_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] acc_q;
  logic                neg_q;
  logic                sgn_q;

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     part_sum;

  // Most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_neg    = signed_i & a_i[DATA_W-1];
  assign b_neg    = signed_i & b_i[DATA_W-1];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;
  assign part_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(DATA_W - 1);
      end else if (busy_q) begin
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Low half of acc_q starts as the multiplier and is consumed LSB first.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      mcand_q <= a_mag;
      acc_q   <= {{DATA_W{1'b0}}, b_mag};
      neg_q   <= a_neg ^ b_neg;
      sgn_q   <= signed_i;
    end else if (busy_q) begin
      acc_q <= {part_sum, acc_q[DATA_W-1:1]};
    end
  end

  assign prod_o   = neg_q ? -acc_q : acc_q;
  assign done_o   = done_q;
  assign signed_o = sgn_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags/branch and output back-pressure.
// Define ALU_MUL_EN to compile in the multi-cycle iterative multiplier (opcode 6).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [4:0]        I_ALUOP,
  input  logic [DATA_W-1:0] I_DATAA,
  input  logic [DATA_W-1:0] I_DATAB,
  input  logic [IMM_W-1:0]  I_IMME,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DATA_W-1:0] O_DATARESULT,
  output logic [DATA_W-1:0] O_MULHI,
  output logic [3:0]        O_FLAGS,
  output logic              O_JMPBRANCH
);

  state_e state_q, state_d;
  alu_op_e opc;
  logic op_lsb, accept, load_alu, load;
  logic signed [DATA_W-1:0] a_s, b_s;
  logic [DATA_W:0] sum_w, diff_w, shl_w, shr_w;
  logic [SH_W-1:0] sh;
  logic [DATA_W-1:0] alu_res, res_d, res_q;
  logic alu_c, alu_v, alu_br, alu_def;
  logic [3:0] flags_d, flags_q;
  logic br_d, br_q;

  assign opc    = alu_op_e'(I_ALUOP[4:1]);
  assign op_lsb = I_ALUOP[0];
  assign a_s    = $signed(I_DATAA);
  assign b_s    = $signed(I_DATAB);
  assign sh     = I_DATAB[SH_W-1:0];
  assign sum_w  = {1'b0, I_DATAA} + {1'b0, I_DATAB};
  assign diff_w = {1'b0, I_DATAA} - {1'b0, I_DATAB};
  // One guard bit on each side captures the last bit shifted out (zero for shift 0).
  assign shl_w  = {1'b0, I_DATAA} << sh;
  assign shr_w  = {I_DATAA, 1'b0} >> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_br  = 1'b0;
    alu_def = 1'b1;
    case (opc)
      OP_ADD: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (I_DATAA[DATA_W-1] == I_DATAB[DATA_W-1]) && (sum_w[DATA_W-1] != I_DATAA[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[DATA_W-1:0];
        alu_c   = diff_w[DATA_W];
        alu_v   = (I_DATAA[DATA_W-1] != I_DATAB[DATA_W-1]) && (diff_w[DATA_W-1] != I_DATAA[DATA_W-1]);
      end
      OP_OR:  alu_res = I_DATAA | I_DATAB;
      OP_AND: alu_res = I_DATAA & I_DATAB;
      OP_XOR: alu_res = I_DATAA ^ I_DATAB;
      OP_NOT: alu_res = ~I_DATAA;
      OP_LOAD: begin
        if (op_lsb) alu_res[DATA_W-1 -: IMM_W] = I_IMME;
        else        alu_res[IMM_W-1:0]         = I_IMME;
      end
      OP_CMP: begin
        alu_res[CMP_EQ] = (I_DATAA == I_DATAB);
        alu_res[CMP_AZ] = (I_DATAA == '0);
        alu_res[CMP_BZ] = (I_DATAB == '0);
        alu_res[CMP_GT] = op_lsb ? (a_s > b_s) : (I_DATAA > I_DATAB);
        alu_res[CMP_LT] = op_lsb ? (a_s < b_s) : (I_DATAA < I_DATAB);
      end
      OP_SHL: begin
        alu_res = shl_w[DATA_W-1:0];
        alu_c   = shl_w[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_w[DATA_W:1];
        alu_c   = shr_w[0];
      end
      OP_JMPA: begin
        alu_res = op_lsb ? I_DATAA : DATA_W'(I_IMME);
        alu_br  = 1'b1;
      end
      OP_JMPR: begin
        alu_res = I_DATAA;
        alu_br  = I_DATAB[{op_lsb, I_IMME[1:0]}];
      end
      default: alu_def = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                  mul_start, mul_done, mul_sgn;
  logic [2*DATA_W-1:0]   mul_prod;
  logic [DATA_W-1:0]     mul_lo, mul_hi, hi_d, hi_q;

  assign mul_start = accept & (opc == OP_MUL);
  assign mul_lo    = mul_prod[DATA_W-1:0];
  assign mul_hi    = mul_prod[2*DATA_W-1:DATA_W];

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk_i    (I_CLK),
    .rst_i    (I_RST),
    .start_i  (mul_start),
    .signed_i (op_lsb),
    .a_i      (I_DATAA),
    .b_i      (I_DATAB),
    .done_o   (mul_done),
    .signed_o (mul_sgn),
    .prod_o   (mul_prod)
  );
`endif

  always_comb begin
    state_d  = state_q;
    O_READY  = 1'b0;
    O_VALID  = 1'b0;
    accept   = 1'b0;
    load_alu = 1'b0;
    case (state_q)
      ST_IDLE: O_READY = 1'b1;
      ST_HOLD: begin
        O_VALID = 1'b1;
        O_READY = I_READY;
        if (I_READY) state_d = ST_IDLE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: if (mul_done) state_d = ST_HOLD;
`endif
      default: state_d = ST_IDLE;
    endcase
    accept = I_VALID & O_READY;
    if (accept) begin
`ifdef ALU_MUL_EN
      if (opc == OP_MUL) begin
        state_d = ST_MUL;
      end else begin
        state_d  = ST_HOLD;
        load_alu = 1'b1;
      end
`else
      state_d  = ST_HOLD;
      load_alu = 1'b1;
`endif
    end
  end

  // Undefined opcodes clear every flag, including Z.
  always_comb begin
    res_d          = alu_res;
    br_d           = alu_br;
    load           = load_alu;
    flags_d        = '0;
    flags_d[FLG_Z] = alu_def && (alu_res == '0);
    flags_d[FLG_N] = alu_def && alu_res[DATA_W-1];
    flags_d[FLG_C] = alu_c;
    flags_d[FLG_V] = alu_v;
`ifdef ALU_MUL_EN
    hi_d = '0;
    if (state_q == ST_MUL) begin
      res_d          = mul_lo;
      hi_d           = mul_hi;
      br_d           = 1'b0;
      load           = mul_done;
      flags_d[FLG_Z] = (mul_lo == '0);
      flags_d[FLG_N] = mul_lo[DATA_W-1];
      flags_d[FLG_C] = !mul_sgn && (mul_hi != '0);
      flags_d[FLG_V] = mul_sgn && (mul_hi != {DATA_W{mul_lo[DATA_W-1]}});
    end
`endif
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flags_q <= '0;
      br_q    <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        res_q   <= res_d;
        flags_q <= flags_d;
        br_q    <= br_d;
`ifdef ALU_MUL_EN
        hi_q    <= hi_d;
`endif
      end
    end
  end

  assign O_DATARESULT = res_q;
  assign O_FLAGS      = flags_q;
  assign O_JMPBRANCH  = br_q;
`ifdef ALU_MUL_EN
  assign O_MULHI      = hi_q;
`else
  assign O_MULHI      = '0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (DATA_W=16): directed steps plus a random stream
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_pipe;

  logic        I_CLK = 1'b0;
  logic        I_RST = 1'b0;
  logic        I_VALID = 1'b0;
  logic        I_READY = 1'b1;
  logic [4:0]  I_ALUOP = '0;
  logic [15:0] I_DATAA = '0;
  logic [15:0] I_DATAB = '0;
  logic [7:0]  I_IMME = '0;
  logic        O_READY, O_VALID, O_JMPBRANCH;
  logic [15:0] O_DATARESULT, O_MULHI;
  logic [3:0]  O_FLAGS;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  flags;
    logic        br;
  } exp_t;

  alu_pipe #(.DATA_W(16), .IMM_W(8)) dut (
    .I_CLK        (I_CLK),
    .I_RST        (I_RST),
    .I_VALID      (I_VALID),
    .O_READY      (O_READY),
    .I_ALUOP      (I_ALUOP),
    .I_DATAA      (I_DATAA),
    .I_DATAB      (I_DATAB),
    .I_IMME       (I_IMME),
    .O_VALID      (O_VALID),
    .I_READY      (I_READY),
    .O_DATARESULT (O_DATARESULT),
    .O_MULHI      (O_MULHI),
    .O_FLAGS      (O_FLAGS),
    .O_JMPBRANCH  (O_JMPBRANCH)
  );

  always #5 I_CLK = ~I_CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(logic [4:0] op, logic [15:0] a, logic [15:0] b, logic [7:0] imm);
    exp_t e;
    longint ua, ub, sa, sb, r, p;
    logic [63:0] rv;
    logic lsb, c, v, def, lt, gt;
    int sh;
    e = '0; r = 0; c = 1'b0; v = 1'b0; def = 1'b1;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    lsb = op[0];
    sh = int'(b[3:0]);
    case (op[4:1])
      4'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: r = ua | ub;
      4'd3: r = ua & ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ~ua;
      4'd8: r = lsb ? longint'(imm) * 256 : longint'(imm);
      4'd9: begin
        lt = lsb ? (sa < sb) : (ua < ub);
        gt = lsb ? (sa > sb) : (ua > ub);
        r = (lt ? 16 : 0) + (gt ? 8 : 0) + (b == 0 ? 4 : 0) + (a == 0 ? 2 : 0) + (a == b ? 1 : 0);
      end
      4'd10: begin r = ua * (longint'(1) << sh); c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1); end
      4'd11: begin r = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'd12: begin r = lsb ? ua : longint'(imm); e.br = 1'b1; end
      4'd13: begin r = ua; e.br = ((ub >> (int'(lsb) * 4 + int'(imm[1:0]))) & 1) == 1; end
`ifdef ALU_MUL_EN
      4'd6: begin
        p = lsb ? sa * sb : ua * ub;
        r = p;
        rv = p;
        e.hi = rv[31:16];
        v = lsb && (p > 32767 || p < -32768);
        c = !lsb && (rv[31:16] != 0);
      end
`endif
      default: def = 1'b0;
    endcase
    rv = r;
    e.res = rv[15:0];
    if (def) e.flags = {v, c, e.res[15], e.res == 16'h0};
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(string tag, exp_t e);
    chk({tag, "/valid"}, 64'(O_VALID), 64'd1);
    chk({tag, "/out"}, 64'({O_DATARESULT, O_MULHI, O_FLAGS, O_JMPBRANCH}), 64'(e));
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic drive(logic [4:0] op, logic [15:0] a, logic [15:0] b, logic [7:0] imm);
    I_VALID = 1'b1;
    I_ALUOP = op;
    I_DATAA = a;
    I_DATAB = b;
    I_IMME  = imm;
  endtask

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [4:0] op;
    logic [15:0] a, b;
    logic [7:0] imm;
    exp_t e, e2;
    int n;

    // Reset state
    #1 I_RST = 1'b1;
    #2;
    chk("rst/ready", 64'(O_READY), 64'd1);
    chk("rst/valid", 64'(O_VALID), 64'd0);
    chk("rst/outs", 64'({O_DATARESULT, O_MULHI, O_FLAGS, O_JMPBRANCH}), 64'd0);
    #4 I_RST = 1'b0;
    tick();

    // Directed boundary cases, streamed back-to-back
    drive({4'd0, 1'b1}, 16'h7FFF, 16'h0001, 8'h00); tick();
    chk("add_ovf", 64'({O_DATARESULT, O_FLAGS}), 64'({16'h8000, 4'b1010}));
    drive({4'd1, 1'b0}, 16'h0000, 16'h0001, 8'h00); tick();
    chk("sub_borrow", 64'({O_DATARESULT, O_FLAGS}), 64'({16'hFFFF, 4'b0110}));
    drive({4'd13, 1'b1}, 16'h1234, 16'h0020, 8'h01); tick();
    chk("jmpr_taken", 64'({O_DATARESULT, O_JMPBRANCH}), 64'({16'h1234, 1'b1}));
    drive({4'd9, 1'b1}, 16'hFFFF, 16'h0001, 8'h00); tick();
    chk("cmp_signed", 64'({O_DATARESULT, O_FLAGS}), 64'({16'h0010, 4'b0000}));
    drive({4'd8, 1'b1}, 16'h0000, 16'h0000, 8'hA5); tick();
    chk("load_hi", 64'(O_DATARESULT), 64'h0000_A500);
    drive({4'd8, 1'b0}, 16'h0000, 16'h0000, 8'hA5); tick();
    chk("load_lo", 64'(O_DATARESULT), 64'h0000_00A5);
    drive({4'd14, 1'b0}, 16'h1111, 16'h2222, 8'h00); tick();
    chk("undef14", 64'({O_DATARESULT, O_MULHI, O_FLAGS, O_JMPBRANCH}), 64'd0);
`ifndef ALU_MUL_EN
    drive({4'd10, 1'b0}, 16'h8001, 16'h0001, 8'h00); tick();
    chk("shl_carry", 64'({O_DATARESULT, O_FLAGS}), 64'({16'h0002, 4'b0100}));
    drive({4'd6, 1'b1}, 16'hFFFD, 16'h0005, 8'h00); tick();
    chk_out("op6_undef", '0);
`endif
    I_VALID = 1'b0; tick();
    chk("idle_after_directed", 64'(O_VALID), 64'd0);
    chk("idle_ready", 64'(O_READY), 64'd1);

    // Random stream, one op per cycle
    for (int i = 0; i < 60; i++) begin
      op = {4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
`ifdef ALU_MUL_EN
      if (op[4:1] == 4'd6) op[4:1] = 4'd4;
`endif
      a = rnd_operand(); b = rnd_operand(); imm = 8'($urandom);
      drive(op, a, b, imm);
      e = model(op, a, b, imm);
      tick();
      chk_out($sformatf("rand%0d_op%0d", i, op), e);
    end
    I_VALID = 1'b0; tick();
    chk("idle_after_stream", 64'(O_VALID), 64'd0);

    // Back-pressure: OR, AND, XOR, NOT with the AND result stalled three cycles
    drive({4'd2, 1'b0}, 16'hF0F0, 16'h0FF0, 8'h00); tick();
    chk_out("bp_or", model({4'd2, 1'b0}, 16'hF0F0, 16'h0FF0, 8'h00));
    drive({4'd3, 1'b0}, 16'hF0F0, 16'h0FF0, 8'h00); tick();
    e = model({4'd3, 1'b0}, 16'hF0F0, 16'h0FF0, 8'h00);
    chk_out("bp_and", e);
    I_READY = 1'b0;
    drive({4'd4, 1'b0}, 16'hAAAA, 16'h5555, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_stall%0d_ready", k), 64'(O_READY), 64'd0);
      chk_out($sformatf("bp_stall%0d", k), e);
      tick();
    end
    chk_out("bp_still_held", e);
    I_READY = 1'b1; tick();
    chk_out("bp_xor", model({4'd4, 1'b0}, 16'hAAAA, 16'h5555, 8'h00));
    drive({4'd5, 1'b0}, 16'h00FF, 16'h0000, 8'h00); tick();
    chk_out("bp_not", model({4'd5, 1'b0}, 16'h00FF, 16'h0000, 8'h00));
    I_VALID = 1'b0; tick();
    chk("bp_idle", 64'(O_VALID), 64'd0);

`ifdef ALU_MUL_EN
    // Signed MUL latency and result; inputs change during the multiply
    drive({4'd6, 1'b1}, 16'hFFFD, 16'h0005, 8'h00); tick();
    I_VALID = 1'b0; I_DATAA = 16'h1234; I_DATAB = 16'h4321;
    chk("mul_ready_low", 64'(O_READY), 64'd0);
    n = 0;
    while (!O_VALID && n < 40) begin tick(); n++; end
    chk("mul_latency", 64'(n), 64'd17);
    chk("mul_signed", 64'({O_DATARESULT, O_MULHI, O_FLAGS}), 64'({16'hFFF1, 16'hFFFF, 4'b0010}));
    for (int i = 0; i < 8; i++) begin
      op = {4'd6, 1'($urandom_range(0, 1))};
      a = rnd_operand(); b = rnd_operand();
      drive(op, a, b, 8'h00);
      e = model(op, a, b, 8'h00);
      tick();
      I_VALID = 1'b0; I_DATAA = 16'($urandom);
      n = 0;
      while (!O_VALID && n < 40) begin tick(); n++; end
      chk($sformatf("mul%0d_latency", i), 64'(n), 64'd17);
      chk_out($sformatf("mul%0d", i), e);
    end
`endif

    // Reset in the middle of work, then a fresh ADD
    drive({4'd1, 1'b0}, 16'h0000, 16'h0001, 8'h00); tick();
    chk("pre_rst_sub", 64'(O_DATARESULT), 64'hFFFF);
`ifdef ALU_MUL_EN
    drive({4'd6, 1'b0}, 16'h00FF, 16'h0101, 8'h00); tick();
    I_VALID = 1'b0;
    for (int k = 0; k < 4; k++) tick();
`else
    I_VALID = 1'b0; I_READY = 1'b0; tick();
`endif
    #3 I_RST = 1'b1;
    #1;
    chk("rst_mid/ready", 64'(O_READY), 64'd1);
    chk("rst_mid/valid", 64'(O_VALID), 64'd0);
    chk("rst_mid/outs", 64'({O_DATARESULT, O_MULHI, O_FLAGS, O_JMPBRANCH}), 64'd0);
    #1 I_RST = 1'b0; I_READY = 1'b1;
    tick();
    chk("post_rst_valid", 64'(O_VALID), 64'd0);
    drive({4'd0, 1'b0}, 16'd3, 16'd4, 8'h00); tick();
    e2 = model({4'd0, 1'b0}, 16'd3, 16'd4, 8'h00);
    chk_out("post_rst_add", e2);
    chk("post_rst_add7", 64'(O_DATARESULT), 64'd7);
    I_VALID = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
